// File: rtl/seq_alu.sv
// Sequential ALU: one-cycle binary ops, plus a nibble-serial BCD add/subtract path
// that walks from the least significant digit with a registered digit carry.
module seq_alu #(
   parameter int WIDTH       = 8,
   parameter bit HAS_DECIMAL = 1'b1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   output logic             READY,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             DEC_En,
   output logic [WIDTH-1:0] RESULT,
   output logic             C,
   output logic             HC,
   output logic             V,
   output logic             N,
   output logic             Z,
   output logic             VALID
);

   // state  | meaning
   // S_IDLE | READY=1, waiting for START
   // S_BIN  | single-cycle binary/logic/shift op, results land at the next edge
   // S_BCD  | one decimal digit per cycle, LS digit first; last digit updates outputs

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_LSR = 3'b101;
   localparam logic [2:0] OP_ASL = 3'b110;
   localparam logic [2:0] OP_ROR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BIN  = 2'd1,
      S_BCD  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-1:0] acc_q;
   logic             nib_c_q;
   logic             hc_dec_q;
   logic [CW-1:0]    cnt_q;

   logic             dec_req;
   logic             last_nib;
   logic             first_nib;

   assign READY     = (state_q == S_IDLE);
   assign dec_req   = HAS_DECIMAL && DEC_En && ((OP == OP_ADD) || (OP == OP_SUB));
   assign last_nib  = (cnt_q == '0);
   assign first_nib = (cnt_q == CW'(NIB - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (START) state_d = dec_req ? S_BCD : S_BIN;
         S_BIN:  state_d = S_IDLE;
         S_BCD:  if (last_nib) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Binary adder; SUB is A + ~B + Cin so Cin=1 means "no borrow".
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   a_ext, b_ext, sum_full;
   logic             add_hc, add_v;

   assign b_eff    = (op_q == OP_SUB) ? ~b_q : b_q;
   assign a_ext    = {1'b0, a_q};
   assign b_ext    = {1'b0, b_eff};
   assign sum_full = a_ext + b_ext + {{WIDTH{1'b0}}, cin_q};
   // Carry into bit 4 recovered from the sum bit; for WIDTH=4 this is the carry out.
   assign add_hc   = a_ext[4] ^ b_ext[4] ^ sum_full[4];
   assign add_v    = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);

   logic [WIDTH-1:0] bin_res;
   logic             bin_c, bin_hc, bin_v;

   always_comb begin
      bin_res = '0;
      bin_c   = cin_q;
      bin_hc  = 1'b0;
      bin_v   = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            bin_res = sum_full[WIDTH-1:0];
            bin_c   = sum_full[WIDTH];
            bin_hc  = add_hc;
            bin_v   = add_v;
         end
         OP_AND: bin_res = a_q & b_q;
         OP_OR:  bin_res = a_q | b_q;
         OP_EOR: bin_res = a_q ^ b_q;
         OP_LSR: begin
            bin_res = a_q >> 1;
            bin_c   = a_q[0];
         end
         OP_ASL: begin
            bin_res = a_q << 1;
            bin_c   = a_q[WIDTH-1];
         end
         OP_ROR: begin
            bin_res = {cin_q, a_q[WIDTH-1:1]};
            bin_c   = a_q[0];
         end
         default: ;
      endcase
   end

   // One decimal digit; invalid digits (>9) go through the same adjust, unclamped.
   logic [3:0]       nib_a, nib_b, nib_res;
   logic [4:0]       dsum, ddif;
   logic             nib_co;
   logic             hc_now;
   logic [WIDTH-1:0] acc_next;

   assign nib_a = a_sh[3:0];
   assign nib_b = b_sh[3:0];
   assign dsum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, nib_c_q};
   assign ddif  = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, ~nib_c_q};

   always_comb begin
      nib_res = dsum[3:0];
      nib_co  = 1'b0;
      if (op_q == OP_SUB) begin
         if (ddif[4]) begin
            nib_res = ddif[3:0] - 4'd6;
            nib_co  = 1'b0;
         end else begin
            nib_res = ddif[3:0];
            nib_co  = 1'b1;
         end
      end else if (dsum > 5'd9) begin
         nib_res = dsum[3:0] + 4'd6;
         nib_co  = 1'b1;
      end
   end

   assign acc_next = (acc_q >> 4) | (WIDTH'(nib_res) << (WIDTH - 4));
   assign hc_now   = first_nib ? nib_co : hc_dec_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         acc_q    <= '0;
         nib_c_q  <= 1'b0;
         hc_dec_q <= 1'b0;
         cnt_q    <= '0;
         RESULT   <= '0;
         C        <= 1'b0;
         HC       <= 1'b0;
         V        <= 1'b0;
         N        <= 1'b0;
         Z        <= 1'b0;
         VALID    <= 1'b0;
      end else begin
         VALID <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  op_q    <= OP;
                  a_q     <= A;
                  b_q     <= B;
                  cin_q   <= Cin;
                  a_sh    <= A;
                  b_sh    <= B;
                  acc_q   <= '0;
                  nib_c_q <= Cin;
                  cnt_q   <= CW'(NIB - 1);
               end
            end
            S_BIN: begin
               RESULT <= bin_res;
               C      <= bin_c;
               HC     <= bin_hc;
               V      <= bin_v;
               N      <= bin_res[WIDTH-1];
               Z      <= (bin_res == '0);
               VALID  <= 1'b1;
            end
            S_BCD: begin
               a_sh    <= a_sh >> 4;
               b_sh    <= b_sh >> 4;
               acc_q   <= acc_next;
               nib_c_q <= nib_co;
               cnt_q   <= cnt_q - 1'b1;
               if (first_nib) hc_dec_q <= nib_co;
               if (last_nib) begin
                  RESULT <= acc_next;
                  C      <= nib_co;
                  HC     <= hc_now;
                  V      <= add_v;
                  N      <= acc_next[WIDTH-1];
                  Z      <= (acc_next == '0);
                  VALID  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: an 8-bit and a 16-bit instance share operand inputs
// but have separate START lines; expected values are hand-computed constants.
module tb_seq_alu;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_LSR = 3'b101;
   localparam logic [2:0] OP_ASL = 3'b110;
   localparam logic [2:0] OP_ROR = 3'b111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start8, start16;
   logic [2:0]  op_i;
   logic [15:0] a_i, b_i;
   logic        cin_i, dec_i;

   logic        ready8, c8, hc8, v8, n8, z8, valid8;
   logic [7:0]  res8;
   logic        ready16, c16, hc16, v16, n16, z16, valid16;
   logic [15:0] res16;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8), .HAS_DECIMAL(1'b1)) u_alu8 (
      .CLK(clk), .RST_N(rst_n), .START(start8), .READY(ready8), .OP(op_i),
      .A(a_i[7:0]), .B(b_i[7:0]), .Cin(cin_i), .DEC_En(dec_i), .RESULT(res8),
      .C(c8), .HC(hc8), .V(v8), .N(n8), .Z(z8), .VALID(valid8)
   );

   seq_alu #(.WIDTH(16), .HAS_DECIMAL(1'b1)) u_alu16 (
      .CLK(clk), .RST_N(rst_n), .START(start16), .READY(ready16), .OP(op_i),
      .A(a_i), .B(b_i), .Cin(cin_i), .DEC_En(dec_i), .RESULT(res16),
      .C(c16), .HC(hc16), .V(v16), .N(n16), .Z(z16), .VALID(valid16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] s_res(input bit w16);
      return w16 ? res16 : {8'h00, res8};
   endfunction

   function automatic logic [4:0] s_flags(input bit w16);
      return w16 ? {c16, hc16, v16, n16, z16} : {c8, hc8, v8, n8, z8};
   endfunction

   function automatic logic s_valid(input bit w16);
      return w16 ? valid16 : valid8;
   endfunction

   function automatic logic s_ready(input bit w16);
      return w16 ? ready16 : ready8;
   endfunction

   // Flags are packed {C, HC, V, N, Z}. Operands are scrambled right after acceptance.
   task automatic run_op(input string tag, input bit w16, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic dec, input int lat, input logic [15:0] prev,
                         input logic [15:0] er, input logic [4:0] ef);
      int got;
      @(negedge clk);
      op_i = op; a_i = a; b_i = b; cin_i = cin; dec_i = dec;
      if (w16) start16 = 1'b1;
      else     start8  = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; start16 = 1'b0;
      op_i = ~op; a_i = ~a; b_i = ~b; cin_i = ~cin; dec_i = ~dec;
      got = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (s_valid(w16)) begin
            got = i;
            break;
         end
         check({tag, " hold"}, 32'(s_res(w16)), 32'(prev));
         check({tag, " busy"}, 32'(s_ready(w16)), 32'd0);
      end
      check({tag, " latency"}, got, lat);
      check({tag, " result"}, 32'(s_res(w16)), 32'(er));
      check({tag, " flags"}, 32'(s_flags(w16)), 32'(ef));
      check({tag, " ready"}, 32'(s_ready(w16)), 32'd1);
      @(posedge clk); #1;
      check({tag, " pulse"}, 32'(s_valid(w16)), 32'd0);
   endtask

   initial begin
      int nval;
      rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
      op_i = OP_ADD; a_i = '0; b_i = '0; cin_i = 1'b0; dec_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst res8",    32'(res8), 32'd0);
      check("rst flags8",  32'({c8, hc8, v8, n8, z8}), 32'd0);
      check("rst valid8",  32'(valid8), 32'd0);
      check("rst ready8",  32'(ready8), 32'd1);
      check("rst res16",   32'(res16), 32'd0);
      check("rst ready16", 32'(ready16), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add7f",   1'b0, OP_ADD, 16'h7F, 16'h01, 1'b0, 1'b0, 1, 16'h00, 16'h80, 5'b01110);
      run_op("dadd",    1'b0, OP_ADD, 16'h58, 16'h46, 1'b1, 1'b1, 2, 16'h80, 16'h05, 5'b11100);
      run_op("dsub1",   1'b0, OP_SUB, 16'h40, 16'h13, 1'b1, 1'b1, 2, 16'h05, 16'h27, 5'b10000);
      run_op("dsub2",   1'b0, OP_SUB, 16'h12, 16'h21, 1'b1, 1'b1, 2, 16'h27, 16'h91, 5'b01010);
      run_op("ror",     1'b0, OP_ROR, 16'h01, 16'h55, 1'b1, 1'b1, 1, 16'h91, 16'h80, 5'b10010);
      run_op("lsr",     1'b0, OP_LSR, 16'h01, 16'hAA, 1'b0, 1'b0, 1, 16'h80, 16'h00, 5'b10001);
      run_op("sub",     1'b0, OP_SUB, 16'h10, 16'h01, 1'b1, 1'b0, 1, 16'h00, 16'h0F, 5'b10000);
      run_op("and",     1'b0, OP_AND, 16'hF0, 16'h3C, 1'b1, 1'b1, 1, 16'h0F, 16'h30, 5'b10000);
      run_op("or",      1'b0, OP_OR,  16'h0F, 16'hA0, 1'b0, 1'b0, 1, 16'h30, 16'hAF, 5'b00010);
      run_op("eor",     1'b0, OP_EOR, 16'hFF, 16'hFF, 1'b1, 1'b0, 1, 16'hAF, 16'h00, 5'b10001);
      run_op("asl",     1'b0, OP_ASL, 16'h81, 16'h00, 1'b0, 1'b0, 1, 16'h00, 16'h02, 5'b10000);
      run_op("dadd_bad",1'b0, OP_ADD, 16'h0A, 16'h00, 1'b0, 1'b1, 2, 16'h02, 16'h10, 5'b01000);

      // Back-to-back: START held high across the edge where READY returns.
      @(negedge clk);
      op_i = OP_ADD; a_i = 16'h01; b_i = 16'h01; cin_i = 1'b0; dec_i = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      a_i = 16'h03; b_i = 16'h04;
      @(posedge clk); #1;
      check("b2b valid1", 32'(valid8), 32'd1);
      check("b2b res1",   32'(res8), 32'h02);
      check("b2b ready1", 32'(ready8), 32'd1);
      @(posedge clk); #1;
      start8 = 1'b0;
      check("b2b accept2", 32'(ready8), 32'd0);
      check("b2b gap",     32'(valid8), 32'd0);
      @(posedge clk); #1;
      check("b2b valid2", 32'(valid8), 32'd1);
      check("b2b res2",   32'(res8), 32'h07);

      // START pulsed while a decimal op is in flight must be ignored.
      @(negedge clk);
      op_i = OP_ADD; a_i = 16'h11; b_i = 16'h22; cin_i = 1'b0; dec_i = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      nval = 0;
      @(negedge clk);
      start8 = 1'b1; op_i = OP_AND; a_i = 16'h00;
      @(posedge clk); #1;
      start8 = 1'b0;
      if (valid8) nval++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (valid8) nval++;
      end
      check("busy start nvalid", nval, 1);
      check("busy start res",    32'(res8), 32'h33);

      // Reset in the middle of a BCD op aborts it.
      @(negedge clk);
      op_i = OP_ADD; a_i = 16'h58; b_i = 16'h46; cin_i = 1'b1; dec_i = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort res",   32'(res8), 32'd0);
      check("abort flags", 32'({c8, hc8, v8, n8, z8}), 32'd0);
      check("abort ready", 32'(ready8), 32'd1);
      @(posedge clk); #1;
      check("abort valid", 32'(valid8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op_i = OP_ADD; a_i = 16'h01; b_i = 16'h01; cin_i = 1'b0; dec_i = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("post rst accept", 32'(ready8), 32'd0);
      check("post rst nvalid", 32'(valid8), 32'd0);
      @(posedge clk); #1;
      check("post rst valid", 32'(valid8), 32'd1);
      check("post rst res",   32'(res8), 32'h02);

      run_op("w16 dadd", 1'b1, OP_ADD, 16'h9999, 16'h0001, 1'b0, 1'b1, 4, 16'h0000, 16'h0000, 5'b11001);
      run_op("w16 add",  1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 16'h8000, 5'b01110);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, operand/result width; multiple of 4, range 4..32.
- HAS_DECIMAL, 1, 1 enables the BCD add/subtract path; 0 forces binary.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock, rising edge.
- RST_N, in, 1, reset; asynchronous, active-low.
- START, in, 1, request an operation.
- READY, out, 1, high when idle and able to accept START.
- OP, in, 3, operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 LSR, 110 ASL, 111 ROR.
- A, in, WIDTH, operand A.
- B, in, WIDTH, operand B.
- Cin, in, 1, carry in (1 = no borrow for SUB).
- DEC_En, in, 1, decimal mode for ADD/SUB.
- RESULT, out, WIDTH, registered result.
- C, out, 1, carry out.
- HC, out, 1, half carry out of nibble 0.
- V, out, 1, overflow.
- N, out, 1, RESULT[WIDTH-1].
- Z, out, 1, high when RESULT == 0.
- VALID, out, 1, one-cycle pulse when RESULT and the flags update.

Function
REQ-003 The block SHALL accept a request at a rising edge where START=1 and READY=1, and SHALL latch OP, A, B, Cin and DEC_En at that edge.
REQ-004 The block SHALL ignore changes to the latched inputs after acceptance, and SHALL ignore START while READY=0.
REQ-005 The state machine SHALL have three states: IDLE (READY=1), BIN, and BCD.
- IDLE goes to BCD on acceptance when OP is ADD or SUB, DEC_En=1 and HAS_DECIMAL=1.
- IDLE goes to BIN on any other acceptance.
REQ-006 BIN SHALL take one cycle: RESULT, flags and VALID update at the edge after acceptance, the state returns to IDLE, and READY=1 from that edge.
REQ-007 BCD SHALL process one nibble per cycle, starting with the least significant nibble, with the nibble carry held in a register.
- Latency is WIDTH/4 edges after acceptance.
- RESULT, flags and VALID update at the final edge, then the state returns to IDLE.
- RESULT SHALL NOT change on intermediate edges.
REQ-008 Binary ADD SHALL compute A+B+Cin; SUB SHALL compute A+~B+Cin. C is the carry out of bit WIDTH-1; V is the two's-complement overflow.
REQ-009 Decimal ADD SHALL compute, per nibble, s = a+b+c.
- If s > 9: add 6, keep the low 4 bits, carry out = 1.
- Otherwise: carry out = 0.
- The rule applies to invalid digits (> 9) too, with no clamping.
REQ-010 Decimal SUB SHALL compute, per nibble, d = a-b-(1-c).
- On borrow: subtract 6 from the nibble (mod 16), carry out = 0.
- On no borrow: carry out = 1.
REQ-011 Decimal mode flags SHALL be set as follows.
- C is the final nibble carry.
- HC is the nibble-0 carry.
- V is the binary overflow of the same operation on the same operands.
- N and Z are taken from the decimal RESULT.
REQ-012 HC SHALL be the carry from bit 3 to bit 4 in binary ADD/SUB and 0 for all other operations.
REQ-013 AND/OR/EOR SHALL produce the bitwise result with C=Cin and V=0.
REQ-014 The shift operations SHALL produce the following, with V=0:
- LSR: {0, A[WIDTH-1:1]}, C=A[0].
- ASL: {A[WIDTH-2:0], 0}, C=A[WIDTH-1].
- ROR: {Cin, A[WIDTH-1:1]}, C=A[0].
REQ-015 Operand B SHALL be ignored by the shift operations, and DEC_En SHALL be ignored for all operations other than ADD and SUB.
REQ-016 RESULT and the flags SHALL hold their values until the next VALID.
REQ-017 Back-to-back operation SHALL be supported: START held high at the edge on which READY returns high is accepted at the next edge.

Reset
REQ-018 While RST_N=0, the block SHALL hold:
- state IDLE;
- RESULT=0;
- C=HC=V=N=Z=0;
- VALID=0;
- READY=1.
REQ-019 Reset asserted mid-operation SHALL abort the operation: no VALID for the aborted request, and the block accepts START at the first edge after RST_N rises.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- WIDTH=8, binary ADD 0x7F+0x01, Cin=0 -> RESULT=0x80, N=1, V=1, C=0, Z=0, HC=1; VALID 1 edge after accept.
- WIDTH=8, decimal ADD 0x58+0x46, Cin=1 -> RESULT=0x05, C=1, HC=1, V=1; VALID 2 edges after accept; RESULT unchanged at edge 1.
- WIDTH=8, decimal SUB 0x40-0x13, Cin=1 -> RESULT=0x27, C=1; then 0x12-0x21, Cin=1 -> RESULT=0x91, C=0, N=1.
- ROR A=0x01, Cin=1 -> RESULT=0x80, C=1, N=1; LSR A=0x01 -> RESULT=0x00, Z=1, C=1.
- START pulsed during a decimal operation -> ignored, exactly one VALID; RST_N low mid-BCD -> no VALID, outputs zero, READY=1.
- WIDTH=16, decimal ADD 0x9999+0x0001, Cin=0 -> RESULT=0x0000, C=1, Z=1; VALID 4 edges after accept.
